// File: rtl/sha_1_pkg.sv
// Shared types and constants for the SHA-1 padder and its word mask.
package sha_1_pkg;

    localparam int unsigned SHA1_BLOCK_WORDS = 16;
    localparam int unsigned SHA1_WORD_W      = 32;
    localparam logic [7:0]  SHA1_PAD_BYTE    = 8'h80;
    localparam logic [SHA1_WORD_W-1:0] SHA1_PAD_WORD = {SHA1_PAD_BYTE, 24'h000000};

    // W0 lives at index 0
    typedef logic [SHA1_BLOCK_WORDS-1:0][SHA1_WORD_W-1:0] sha1_block_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        PAD  = 3'd2,
        LEN  = 3'd3,
        HOLD = 3'd4,
        GAP  = 3'd5
    } pad_state_t;

endpackage

// File: rtl/sha_1_word_mask.sv
// Inserts the 0x80 pad byte after the valid bytes of a final word and zeroes the rest.
module sha_1_word_mask
    import sha_1_pkg::*;
(
    input  logic [SHA1_WORD_W-1:0] in_data,
    input  logic [2:0]             in_nbytes,
    output logic [SHA1_WORD_W-1:0] pad_word
);

    // Valid bytes are counted from the MSB; 4 or more leaves the word untouched
    always_comb begin
        pad_word = in_data;
        unique case (in_nbytes)
            3'd0:    pad_word = {SHA1_PAD_BYTE, 24'h000000};
            3'd1:    pad_word = {in_data[31:24], SHA1_PAD_BYTE, 16'h0000};
            3'd2:    pad_word = {in_data[31:16], SHA1_PAD_BYTE, 8'h00};
            3'd3:    pad_word = {in_data[31:8], SHA1_PAD_BYTE};
            default: pad_word = in_data;
        endcase
    end

endmodule

// File: rtl/sha_1_padder.sv
// FIPS 180-4 padder feeding 512-bit blocks to the SHA-1 core over a level start/done handshake.
// Optional block counter output enabled by defining SHA_1_PADDER_BLKCNT_EN.
module sha_1_padder
    import sha_1_pkg::*;
#(
    parameter int unsigned LEN_W      = 64,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SHA1_WORD_W-1:0] in_data,
    input  logic                   in_last,
    input  logic [2:0]             in_nbytes,
    output sha1_block_t            blk_data,
    output logic                   blk_start,
    output logic                   blk_first,
    output logic                   blk_last,
    input  logic                   blk_done,
`ifdef SHA_1_PADDER_BLKCNT_EN
    output logic [15:0]            blk_count,
`endif
    output logic                   msg_done
);

    localparam int unsigned WI_W  = 5;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    pad_state_t       state;
    logic [WI_W-1:0]  wi;
    logic [LEN_W-1:0] len_q;
    logic             pend80;
    logic             pad_next;
    logic             done_seen;
    logic             hold_armed;
    logic [GAP_W-1:0] gap_cnt;

    logic                   accept_c;
    logic                   first_beat_c;
    logic                   hold_exit_c;
    logic                   short_last_c;
    logic [2:0]             eff_nb_c;
    logic [LEN_W-1:0]       len_inc_c;
    logic [63:0]            len64_c;
    logic [SHA1_WORD_W-1:0] pad_word_c;
    logic [SHA1_WORD_W-1:0] word_c;

    sha_1_word_mask u_word_mask (
        .in_data   (in_data),
        .in_nbytes (in_nbytes),
        .pad_word  (pad_word_c)
    );

    // Beat decode: non-final words always count as four bytes
    always_comb begin
        accept_c     = in_valid && in_ready;
        first_beat_c = accept_c && (state == IDLE);
        short_last_c = in_last && (in_nbytes < 3'd4);
        eff_nb_c     = short_last_c ? in_nbytes : 3'd4;
        len_inc_c    = LEN_W'({eff_nb_c, 3'b000});
        word_c       = short_last_c ? pad_word_c : in_data;
        len64_c      = 64'(len_q);
        hold_exit_c  = (state == HOLD) && hold_armed && (blk_done || done_seen);
    end

    // Padder FSM with registered handshake outputs and block words
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wi         <= '0;
            len_q      <= '0;
            pend80     <= 1'b0;
            pad_next   <= 1'b0;
            done_seen  <= 1'b0;
            hold_armed <= 1'b0;
            gap_cnt    <= '0;
            in_ready   <= 1'b0;
            blk_data   <= '0;
            blk_start  <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            msg_done   <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (first_beat_c) begin
                        blk_data[0] <= word_c;
                        wi          <= WI_W'(1);
                        len_q       <= len_inc_c;
                        blk_first   <= 1'b1;
                        pend80      <= in_last && !short_last_c;
                        if (in_last) begin
                            state    <= PAD;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= FILL;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (wi == WI_W'(SHA1_BLOCK_WORDS)) begin
                        state      <= HOLD;
                        blk_start  <= 1'b1;
                        hold_armed <= 1'b0;
                        done_seen  <= 1'b0;
                    end else if (accept_c) begin
                        blk_data[wi[3:0]] <= word_c;
                        wi                <= wi + WI_W'(1);
                        len_q             <= len_q + len_inc_c;
                        if (in_last) begin
                            pend80   <= !short_last_c;
                            state    <= PAD;
                            in_ready <= 1'b0;
                        end else if (wi == WI_W'(SHA1_BLOCK_WORDS - 1)) begin
                            in_ready <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    if (pend80 && (wi < WI_W'(SHA1_BLOCK_WORDS))) begin
                        blk_data[wi[3:0]] <= SHA1_PAD_WORD;
                        pend80            <= 1'b0;
                        wi                <= wi + WI_W'(1);
                    end else if (wi < WI_W'(14)) begin
                        blk_data[wi[3:0]] <= '0;
                        wi                <= wi + WI_W'(1);
                    end else if (wi == WI_W'(14)) begin
                        state <= LEN;
                    end else if (wi == WI_W'(15)) begin
                        blk_data[15] <= '0;
                        wi           <= WI_W'(16);
                    end else begin
                        // Block full before the length fits: another pad block follows
                        state      <= HOLD;
                        pad_next   <= 1'b1;
                        blk_start  <= 1'b1;
                        hold_armed <= 1'b0;
                        done_seen  <= 1'b0;
                    end
                end
                LEN: begin
                    blk_data[14] <= len64_c[63:32];
                    blk_data[15] <= len64_c[31:0];
                    blk_last     <= 1'b1;
                    state        <= HOLD;
                    blk_start    <= 1'b1;
                    hold_armed   <= 1'b0;
                    done_seen    <= 1'b0;
                end
                HOLD: begin
                    // First high cycle only arms; an early done is remembered
                    hold_armed <= 1'b1;
                    if (hold_exit_c) begin
                        blk_start <= 1'b0;
                        msg_done  <= blk_last;
                        done_seen <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else if (blk_done) begin
                        done_seen <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        blk_data  <= '0;
                        wi        <= '0;
                        blk_first <= 1'b0;
                        blk_last  <= 1'b0;
                        if (pad_next) begin
                            pad_next <= 1'b0;
                            state    <= PAD;
                        end else if (blk_last) begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end else begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHA_1_PADDER_BLKCNT_EN
    // Saturating count of blocks accepted by the core within the current message
    always_ff @(posedge clk) begin
        if (reset || first_beat_c) begin
            blk_count <= '0;
        end else if (hold_exit_c && (blk_count != 16'hFFFF)) begin
            blk_count <= blk_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sha_1_padder.sv
// Directed bench for sha_1_padder: FIPS padding cases, handshake timing and reset in HOLD.
module tb_sha_1_padder;
    import sha_1_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_nbytes;
    sha1_block_t blk_data;
    logic        blk_start;
    logic        blk_first;
    logic        blk_last;
    logic        blk_done;
    logic        msg_done;
`ifdef SHA_1_PADDER_BLKCNT_EN
    logic [15:0] blk_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_w [16];

    always #5 clk = ~clk;

    sha_1_padder #(.LEN_W(64), .GAP_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .blk_data  (blk_data),
        .blk_start (blk_start),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .blk_done  (blk_done),
`ifdef SHA_1_PADDER_BLKCNT_EN
        .blk_count (blk_count),
`endif
        .msg_done  (msg_done)
    );

    function automatic logic [31:0] dw(input int i);
        logic [7:0] b;
        b = 8'(i + 1);
        return {b, b, b, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_exp_data(input int nwords);
        for (int i = 0; i < 16; i++) exp_w[i] = (i < nwords) ? dw(i) : 32'h0;
    endtask

    // Present one beat from a negedge; returns at the negedge after it transferred
    task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_nbytes = nb; in_last = last;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_ready_timeout", 32'(n), 32'(0));
        @(negedge clk);
        in_valid = 1'b0; in_data = '0; in_nbytes = '0; in_last = 1'b0;
    endtask

    task automatic check_block(input string tag, input int max_wait, input logic ef, input logic el);
        int n = 0;
        while (blk_start !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_start_in_time", tag), 32'(n <= max_wait), 32'(1));
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_w%0d", tag, i), blk_data[i], exp_w[i]);
        chk($sformatf("%s_first", tag), 32'(blk_first), 32'(ef));
        chk($sformatf("%s_last", tag), 32'(blk_last), 32'(el));
        chk($sformatf("%s_ready_low", tag), 32'(in_ready), 32'(0));
    endtask

    // Return blk_done after 'delay' cycles and check the hold/drop behaviour
    task automatic handshake(input string tag, input int delay, input logic el);
        int hi = 1;
        int n  = 0;
        repeat (delay) begin
            @(negedge clk);
            if (blk_start === 1'b1) hi++;
        end
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        while (blk_start === 1'b1 && n < 50) begin
            hi++;
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_start_drop", tag), 32'(blk_start), 32'(0));
        chk($sformatf("%s_msg_done", tag), 32'(msg_done), 32'(el));
        chk($sformatf("%s_hold_ge2", tag), 32'(hi >= 2), 32'(1));
    endtask

    task automatic measure_gap(input string tag);
        int lo = 0;
        while (blk_start !== 1'b1 && lo < 400) begin
            lo++;
            @(negedge clk);
        end
        chk($sformatf("%s_gap_ge4", tag), 32'((lo >= 4) && (lo < 400)), 32'(1));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_nbytes = '0; blk_done = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_blk_start", 32'(blk_start), 32'(0));
        chk("rst_blk_first", 32'(blk_first), 32'(0));
        chk("rst_blk_last", 32'(blk_last), 32'(0));
        chk("rst_msg_done", 32'(msg_done), 32'(0));
        vectors++;
        assert (blk_data === '0) else begin
            miscompares++;
            $error("FAIL rst_blk_data: observed %h expected 0", blk_data);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'(1));

        // "abc"
        send(32'h61626300, 3'd3, 1'b1);
        set_exp_data(0);
        exp_w[0] = 32'h61626380; exp_w[15] = 32'h00000018;
        check_block("abc", 18, 1'b1, 1'b1);
        handshake("abc", 0, 1'b1);
        @(negedge clk);
        chk("abc_msg_done_pulse", 32'(msg_done), 32'(0));

        // Empty message
        send(32'h00000000, 3'd0, 1'b1);
        set_exp_data(0);
        exp_w[0] = 32'h80000000;
        check_block("empty", 400, 1'b1, 1'b1);
        handshake("empty", 2, 1'b1);

        // 55 bytes: pad byte lands in the low byte of W13
        for (int i = 0; i < 13; i++) send(dw(i), 3'd4, 1'b0);
        send(dw(13), 3'd3, 1'b1);
        set_exp_data(13);
        exp_w[13] = 32'h0E0E0E80; exp_w[15] = 32'h000001B8;
        check_block("b55", 400, 1'b1, 1'b1);
        handshake("b55", 0, 1'b1);

        // 56 bytes: length spills into a second block
        for (int i = 0; i < 14; i++) send(dw(i), 3'd4, i == 13);
        set_exp_data(14);
        exp_w[14] = 32'h80000000;
        check_block("b56_1", 400, 1'b1, 1'b0);
        handshake("b56_1", 0, 1'b0);
        set_exp_data(0);
        exp_w[15] = 32'h000001C0;
        check_block("b56_2", 400, 1'b0, 1'b1);
        handshake("b56_2", 0, 1'b1);
`ifdef SHA_1_PADDER_BLKCNT_EN
        chk("b56_blk_count", 32'(blk_count), 32'(2));
`endif

        // 64 bytes, done returned one cycle after start
        for (int i = 0; i < 16; i++) send(dw(i), 3'd4, i == 15);
        set_exp_data(16);
        check_block("b64_1", 400, 1'b1, 1'b0);
        handshake("b64_1", 1, 1'b0);
        measure_gap("b64");
        set_exp_data(0);
        exp_w[0] = 32'h80000000; exp_w[15] = 32'h00000200;
        check_block("b64_2", 400, 1'b0, 1'b1);
        handshake("b64_2", 1, 1'b1);

        // Reset while a block is held
        send(32'h61626300, 3'd3, 1'b1);
        set_exp_data(0);
        exp_w[0] = 32'h61626380; exp_w[15] = 32'h00000018;
        check_block("pre_rst", 18, 1'b1, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("hold_rst_start", 32'(blk_start), 32'(0));
        chk("hold_rst_ready", 32'(in_ready), 32'(0));
        chk("hold_rst_first", 32'(blk_first), 32'(0));
        vectors++;
        assert (blk_data === '0) else begin
            miscompares++;
            $error("FAIL hold_rst_blk_data: observed %h expected 0", blk_data);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'(1));
        send(32'h61626300, 3'd3, 1'b1);
        check_block("abc2", 18, 1'b1, 1'b1);
        handshake("abc2", 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
